l1_biu: RTL and testbench

- Synchronous bus interface unit directly downstream of the L1 instruction cache controller.
- Services the controller's line-fill, single-read and write-through requests over an 8-bit external master bus.
- Returns the byte stream, fill counter and write strobes for cache RAM refill, plus completion and error indications.
- Includes a per-beat timeout watchdog that converts a hung slave into a bus error.

---
 rtl/l1_biu.sv | 153 +++++++++++++++
 tb/tb_l1_biu.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_biu.sv
// l1_biu: bus interface unit behind the L1 instruction cache controller.
// It turns line-fill, single-read and write-through requests into beats on
// an 8-bit external master bus. A per-beat watchdog turns a hung slave into
// a bus error.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a request; latches address, data, clears counters
// LINE_RD | ext_rd beat for byte addr_count of the aligned line
// LINE_WR | one-cycle cache RAM write strobe, then advance addr_count
// SGL_RD  | ext_rd beat for a single byte at addr_q
// SGL_WR  | ext_wr beat for a single byte at addr_q
// DONE    | one-cycle bus_trans_finish pulse
// ERR     | one-cycle bus_error pulse (slave error or timeout)
module l1_biu #(
    parameter int ADDR_WIDTH  = 24,
    parameter int LINE_BYTES  = 256,
    parameter int TIMEOUT_CYC = 255,
    parameter int TO_WID      = 8,
    localparam int CNT_WID    = $clog2(LINE_BYTES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_line_req,
    input  logic                  read_req,
    input  logic                  write_through_req,
    input  logic [ADDR_WIDTH-1:0] bus_pa,
    input  logic [7:0]            bus_wdata,
    output logic [7:0]            bus_rdata,
    output logic [CNT_WID-1:0]    addr_count,
    output logic                  line_write,
    output logic                  bus_trans_finish,
    output logic                  bus_error,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ext_addr,
    output logic [7:0]            ext_wdata,
    output logic                  ext_rd,
    output logic                  ext_wr,
    input  logic [7:0]            ext_rdata,
    input  logic                  ext_ack,
    input  logic                  ext_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LINE_RD = 3'd1,
        LINE_WR = 3'd2,
        SGL_RD  = 3'd3,
        SGL_WR  = 3'd4,
        DONE    = 3'd5,
        ERR     = 3'd6
    } state_t;

    // The watchdog fires on the cycle the counter would reach TIMEOUT_CYC,
    // so a beat waits exactly TIMEOUT_CYC cycles before ERR.
    localparam logic [TO_WID-1:0] TO_LAST =
        TO_WID'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    localparam logic [CNT_WID-1:0] CNT_LAST = CNT_WID'(LINE_BYTES - 1);

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              wdata_q;
    logic [TO_WID-1:0]       to_cnt;
    logic                    beat_act;
    logic                    to_hit;

    // Next-state decode: request priority in IDLE, ack/error/timeout per beat.
    always_comb begin
        state_d  = state_q;
        beat_act = (state_q == LINE_RD) || (state_q == SGL_RD) ||
                   (state_q == SGL_WR);
        to_hit   = (TIMEOUT_CYC != 0) && beat_act && !ext_ack &&
                   (to_cnt == TO_LAST);
        case (state_q)
            IDLE: begin
                if (read_line_req)          state_d = LINE_RD;
                else if (read_req)          state_d = SGL_RD;
                else if (write_through_req) state_d = SGL_WR;
            end
            LINE_RD: begin
                if (ext_ack)     state_d = ext_err ? ERR : LINE_WR;
                else if (to_hit) state_d = ERR;
            end
            LINE_WR: state_d = (addr_count == CNT_LAST) ? DONE : LINE_RD;
            SGL_RD, SGL_WR: begin
                if (ext_ack)     state_d = ext_err ? ERR : DONE;
                else if (to_hit) state_d = ERR;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, registered strobes (decoded from next state) and datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            wdata_q          <= '0;
            to_cnt           <= '0;
            addr_count       <= '0;
            bus_rdata        <= '0;
            ext_rd           <= 1'b0;
            ext_wr           <= 1'b0;
            line_write       <= 1'b0;
            bus_trans_finish <= 1'b0;
            bus_error        <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state_q          <= state_d;
            ext_rd           <= (state_d == LINE_RD) || (state_d == SGL_RD);
            ext_wr           <= (state_d == SGL_WR);
            line_write       <= (state_d == LINE_WR);
            bus_trans_finish <= (state_d == DONE);
            bus_error        <= (state_d == ERR);
            busy             <= (state_d != IDLE);
            case (state_q)
                IDLE: begin
                    if (state_d != IDLE) begin
                        addr_q     <= bus_pa;
                        wdata_q    <= bus_wdata;
                        addr_count <= '0;
                        to_cnt     <= '0;
                    end
                end
                LINE_RD, SGL_RD, SGL_WR: begin
                    if (ext_ack) begin
                        to_cnt <= '0;
                        if (!ext_err && (state_q != SGL_WR))
                            bus_rdata <= ext_rdata;
                    end else if (TIMEOUT_CYC != 0) begin
                        to_cnt <= to_cnt + TO_WID'(1);
                    end
                end
                // Final increment wraps addr_count back to 0.
                LINE_WR: addr_count <= addr_count + CNT_WID'(1);
                default: ;
            endcase
        end
    end

    // Line beats use the aligned line base; single accesses use the raw address.
    always_comb begin
        ext_addr = addr_q;
        if ((state_q == LINE_RD) || (state_q == LINE_WR))
            ext_addr = {addr_q[ADDR_WIDTH-1:CNT_WID], addr_count};
    end

    assign ext_wdata = wdata_q;

endmodule

// File: tb/tb_l1_biu.sv
// tb_l1_biu: scoreboard bench for l1_biu. A behavioural slave with
// configurable wait states, error byte and no-ack mode answers the bus;
// expected beats, line writes and completion events are queued at issue
// time and popped as the DUT produces them.
module tb_l1_biu;

    localparam int AW = 24;
    localparam int LB = 256;
    localparam int TO = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          read_line_req = 1'b0;
    logic          read_req = 1'b0;
    logic          write_through_req = 1'b0;
    logic [AW-1:0] bus_pa = '0;
    logic [7:0]    bus_wdata = '0;
    logic [7:0]    bus_rdata;
    logic [7:0]    addr_count;
    logic          line_write;
    logic          bus_trans_finish;
    logic          bus_error;
    logic          busy;
    logic [AW-1:0] ext_addr;
    logic [7:0]    ext_wdata;
    logic          ext_rd;
    logic          ext_wr;
    logic [7:0]    ext_rdata;
    logic          ext_ack;
    logic          ext_err;

    l1_biu #(.ADDR_WIDTH(AW), .LINE_BYTES(LB), .TIMEOUT_CYC(TO), .TO_WID(8)) dut (
        .clk(clk), .rst(rst),
        .read_line_req(read_line_req), .read_req(read_req),
        .write_through_req(write_through_req),
        .bus_pa(bus_pa), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .addr_count(addr_count), .line_write(line_write),
        .bus_trans_finish(bus_trans_finish), .bus_error(bus_error), .busy(busy),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_rd(ext_rd), .ext_wr(ext_wr),
        .ext_rdata(ext_rdata), .ext_ack(ext_ack), .ext_err(ext_err)
    );

    always #5 clk = ~clk;

    // Slave model
    int         wait_states = 0;
    int         wcnt = 0;
    logic       no_ack = 1'b0;
    logic       err_en = 1'b0;
    logic [7:0] err_byte = 8'd0;
    logic       fixed_en = 1'b0;
    logic [7:0] fixed_data = 8'd0;

    always @(posedge clk or negedge rst) begin
        if (!rst)                            wcnt <= 0;
        else if ((ext_rd || ext_wr) && !ext_ack) wcnt <= wcnt + 1;
        else                                 wcnt <= 0;
    end

    assign ext_ack   = (ext_rd || ext_wr) && !no_ack && (wcnt == wait_states);
    assign ext_err   = ext_ack && err_en && (ext_addr[7:0] == err_byte);
    assign ext_rdata = fixed_en ? fixed_data : ext_addr[7:0];

    wire [53:0] all_out = {bus_rdata, addr_count, line_write, bus_trans_finish,
                           bus_error, busy, ext_addr, ext_wdata, ext_rd, ext_wr};

    // Scoreboard
    typedef struct { logic wr; logic [AW-1:0] addr; logic [7:0] wdata; } beat_t;
    typedef struct { logic is_err; int cyc; logic [7:0] rdata; } ev_t;

    beat_t       exp_beat[$];
    logic [15:0] exp_lw[$];
    ev_t         exp_ev[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int req_cyc = 0;
    int rd_hi = 0;
    int wr_hi = 0;
    int lw_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: sample away from the rising edge.
    initial begin
        beat_t       b;
        logic [15:0] e;
        ev_t         v;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (ext_rd) rd_hi++;
                if (ext_wr) wr_hi++;
                if ((ext_rd || ext_wr) && ext_ack) begin
                    if (exp_beat.size() == 0) chk("beat_queue", exp_beat.size(), 1);
                    else begin
                        b = exp_beat.pop_front();
                        chk("beat_addr", ext_addr, b.addr);
                        chk("beat_dir", {ext_rd, ext_wr}, b.wr ? 2'b01 : 2'b10);
                        if (b.wr) chk("beat_wdata", ext_wdata, b.wdata);
                    end
                end
                if (line_write) begin
                    lw_seen++;
                    if (exp_lw.size() == 0) chk("lw_queue", exp_lw.size(), 1);
                    else begin
                        e = exp_lw.pop_front();
                        chk("lw_count", addr_count, e[15:8]);
                        chk("lw_data", bus_rdata, e[7:0]);
                    end
                end
                if (bus_trans_finish || bus_error) begin
                    if (exp_ev.size() == 0) chk("ev_queue", exp_ev.size(), 1);
                    else begin
                        v = exp_ev.pop_front();
                        chk("ev_kind", {bus_trans_finish, bus_error}, v.is_err ? 2'b01 : 2'b10);
                        chk("ev_cycle", cyc - req_cyc, v.cyc);
                        chk("ev_rdata", bus_rdata, v.rdata);
                        chk("ev_strobes", {ext_rd, ext_wr, line_write}, 3'b000);
                        chk("ev_busy", busy, 1'b1);
                    end
                end
            end
        end
    end

    task automatic issue(input int kind, input logic [AW-1:0] pa, input logic [7:0] wd);
        bus_pa    = pa;
        bus_wdata = wd;
        rd_hi     = 0;
        wr_hi     = 0;
        lw_seen   = 0;
        case (kind)
            0:       read_line_req = 1'b1;
            1:       read_req = 1'b1;
            default: write_through_req = 1'b1;
        endcase
        req_cyc = cyc;
        @(posedge clk); #1;
        read_line_req     = 1'b0;
        read_req          = 1'b0;
        write_through_req = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_ev.size() != 0) && (n < budget)) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_done"}, exp_ev.size(), 0);
        chk({tag, "_idle"}, busy, 1'b0);
        chk({tag, "_beats_left"}, exp_beat.size(), 0);
        chk({tag, "_lw_left"}, exp_lw.size(), 0);
    endtask

    function automatic ev_t mk_ev(input logic is_err, input int c, input logic [7:0] rd);
        ev_t v;
        v.is_err = is_err;
        v.cyc    = c;
        v.rdata  = rd;
        return v;
    endfunction

    function automatic beat_t mk_beat(input logic wr, input logic [AW-1:0] a, input logic [7:0] d);
        beat_t b;
        b.wr    = wr;
        b.addr  = a;
        b.wdata = d;
        return b;
    endfunction

    initial begin
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_out, 54'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", {busy, ext_rd, ext_wr}, 3'b000);

        // 1: zero-wait line fill from a mid-line address
        for (int i = 0; i < LB; i++) begin
            exp_beat.push_back(mk_beat(1'b0, 24'h012300 + AW'(i), 8'h00));
            exp_lw.push_back({8'(i), 8'(i)});
        end
        exp_ev.push_back(mk_ev(1'b0, 2 * LB + 1, 8'hFF));
        issue(0, 24'h0123FE, 8'h00);
        drain("t1", 700);
        chk("t1_lw_total", lw_seen, LB);

        // 2: single read, 3 wait states
        wait_states = 3;
        fixed_en    = 1'b1;
        fixed_data  = 8'h5A;
        exp_beat.push_back(mk_beat(1'b0, 24'h00ABCD, 8'h00));
        exp_ev.push_back(mk_ev(1'b0, 5, 8'h5A));
        issue(1, 24'h00ABCD, 8'h00);
        drain("t2", 30);
        chk("t2_rd_cycles", rd_hi, 4);
        chk("t2_wr_cycles", wr_hi, 0);

        // 3: zero-wait write-through
        wait_states = 0;
        exp_beat.push_back(mk_beat(1'b1, 24'h100000, 8'hC3));
        exp_ev.push_back(mk_ev(1'b0, 2, 8'h5A));
        issue(2, 24'h100000, 8'hC3);
        drain("t3", 30);
        chk("t3_wr_cycles", wr_hi, 1);
        chk("t3_rd_cycles", rd_hi, 0);

        // 4: line fill aborted by slave error on byte 5
        fixed_en = 1'b0;
        err_en   = 1'b1;
        err_byte = 8'd5;
        for (int i = 0; i <= 5; i++) begin
            exp_beat.push_back(mk_beat(1'b0, 24'h0A5500 + AW'(i), 8'h00));
            if (i < 5) exp_lw.push_back({8'(i), 8'(i)});
        end
        exp_ev.push_back(mk_ev(1'b1, 12, 8'h04));
        issue(0, 24'h0A5500, 8'h00);
        drain("t4", 60);
        chk("t4_lw_total", lw_seen, 5);
        err_en = 1'b0;

        // 5: slave never acks, watchdog forces the error
        no_ack = 1'b1;
        exp_ev.push_back(mk_ev(1'b1, TO + 1, 8'h04));
        issue(1, 24'h000777, 8'h00);
        drain("t5", 40);
        chk("t5_rd_cycles", rd_hi, TO);
        no_ack = 1'b0;

        // 6: reset in the middle of a fill
        for (int i = 0; i < LB; i++) begin
            exp_beat.push_back(mk_beat(1'b0, 24'h020000 + AW'(i), 8'h00));
            exp_lw.push_back({8'(i), 8'(i)});
        end
        exp_ev.push_back(mk_ev(1'b0, 2 * LB + 1, 8'hFF));
        issue(0, 24'h020000, 8'h00);
        n = 0;
        while ((lw_seen < 40) && (n < 200)) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t6_reach_byte40", lw_seen >= 40, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_reset_outputs", all_out, 54'd0);
        exp_beat.delete();
        exp_lw.delete();
        exp_ev.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("t6_held_outputs", all_out, 54'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        fixed_en   = 1'b1;
        fixed_data = 8'h77;
        exp_beat.push_back(mk_beat(1'b0, 24'h000042, 8'h00));
        exp_ev.push_back(mk_ev(1'b0, 2, 8'h77));
        issue(1, 24'h000042, 8'h00);
        drain("t6", 30);
        chk("t6_addr_count", addr_count, 8'd0);
        chk("t6_rdata", bus_rdata, 8'h77);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got sim time %0t expected completion", $time);
        $fatal(1, "bench timeout");
    end

endmodule
